// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative write-back / write-allocate data cache controller with flop-based storage.
// Optional hit/miss/write-back counters are built when DCACHE_STATS_EN is defined.
module dcache_2way_ctrl #(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDR_W-1:0]    p1_addr_i,
    input  logic [31:0]          p1_data_i,
    input  logic                 p1_MemRead_i,
    input  logic                 p1_MemWrite_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o,
    output logic [31:0]          wb_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFS_W = $clog2(LINE_BITS / 8);
    localparam int TAG_W = ADDR_W - IDX_W - OFS_W;
    localparam int WORDS = LINE_BITS / 32;
    localparam int WRD_W = OFS_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_t;

    state_t               r_state, w_state_next;
    logic [TAG_W-1:0]     r_tag   [2][NUM_SETS];
    logic [LINE_BITS-1:0] r_data  [2][NUM_SETS];
    logic [NUM_SETS-1:0]  r_valid [2];
    logic [NUM_SETS-1:0]  r_dirty [2];
    logic [NUM_SETS-1:0]  r_lru;
    logic                 r_victim;
    logic [TAG_W-1:0]     r_req_tag;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_replay;

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [WRD_W-1:0]     w_word;
    logic                 w_req, w_hit0, w_hit1, w_hit, w_miss, w_fill;
    logic                 w_hit_way, w_victim, w_victim_dirty;
    logic [LINE_BITS-1:0] w_hit_line, w_merge_line;
    logic [31:0]          w_words [WORDS];
    logic                 w_unused;

    assign w_tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx    = p1_addr_i[OFS_W +: IDX_W];
    assign w_word   = p1_addr_i[2 +: WRD_W];
    assign w_unused = ^p1_addr_i[1:0];

    assign w_req     = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = (r_state == S_IDLE) && w_req && (w_hit0 || w_hit1);
    assign w_miss    = (r_state == S_IDLE) && w_req && !(w_hit0 || w_hit1);
    assign w_fill    = (r_state == S_ALLOC) && mem_ack_i;
    assign w_hit_way = !w_hit0;
    assign w_hit_line = r_data[w_hit_way][w_idx];

    // Fill invalid ways in order before evicting the least recently used one.
    assign w_victim       = !r_valid[0][w_idx] ? 1'b0 :
                            !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign w_words[gi] = w_hit_line[gi*32 +: 32];
        assign w_merge_line[gi*32 +: 32] = (w_word == WRD_W'(gi)) ? p1_data_i
                                                                   : w_hit_line[gi*32 +: 32];
    end

    assign p1_data_o  = w_hit ? w_words[w_word] : 32'h0;
    assign p1_stall_o = (r_state != S_IDLE) || w_miss;

    assign mem_enable_o = (r_state != S_IDLE);
    assign mem_write_o  = (r_state == S_WB);
    assign mem_data_o   = (r_state == S_WB) ? r_data[r_victim][r_idx] : '0;
    always_comb begin
        mem_addr_o = '0;
        if (r_state == S_WB)
            mem_addr_o = {r_tag[r_victim][r_idx], r_idx, {OFS_W{1'b0}}};
        else if (r_state == S_ALLOC)
            mem_addr_o = {r_req_tag, r_idx, {OFS_W{1'b0}}};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_state_next = w_victim_dirty ? S_WB : S_ALLOC;
            S_WB:    if (mem_ack_i) w_state_next = S_ALLOC;
            S_ALLOC: if (mem_ack_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_dirty[0] <= '0;
            r_dirty[1] <= '0;
            r_lru     <= '0;
            r_victim  <= 1'b0;
            r_req_tag <= '0;
            r_idx     <= '0;
            r_replay  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_replay <= w_fill;
            if (w_miss) begin
                r_victim  <= w_victim;
                r_req_tag <= w_tag;
                r_idx     <= w_idx;
            end
            if (w_hit) begin
                r_lru[w_idx] <= !w_hit_way;
                if (p1_MemWrite_i)
                    r_dirty[w_hit_way][w_idx] <= 1'b1;
            end
            if (w_fill) begin
                r_valid[r_victim][r_idx] <= 1'b1;
                r_dirty[r_victim][r_idx] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (w_hit && p1_MemWrite_i)
            r_data[w_hit_way][w_idx] <= w_merge_line;
        if (w_fill) begin
            r_data[r_victim][r_idx] <= mem_data_i;
            r_tag[r_victim][r_idx]  <= r_req_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (w_miss)                        r_miss_cnt <= r_miss_cnt + 32'd1;
            if (r_state == S_WB && mem_ack_i)  r_wb_cnt   <= r_wb_cnt + 32'd1;
            if (w_hit && !r_replay)            r_hit_cnt  <= r_hit_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
    assign wb_cnt_o   = r_wb_cnt;
`endif
endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Self-checking bench for dcache_2way_ctrl: directed cache scenarios plus random traffic
// compared against a set/way reference model and a line-granular memory emulator.
module tb_dcache_2way_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_MemRead_i, p1_MemWrite_i, p1_stall_o;
    logic [255:0] mem_data_i, mem_data_o;
    logic         mem_ack_i, mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o, wb_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    dcache_2way_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
        .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
        .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_o),
        .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
`ifdef DCACHE_STATS_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
`endif
    );

    // Memory emulator (driven by DUT traffic) and the reference model's own memory image.
    logic [255:0] phys_mem [logic [31:0]];
    logic [255:0] ref_mem  [logic [31:0]];

    // Reference cache state: per set, two ways plus one LRU bit.
    logic         m_valid [16][2];
    logic         m_dirty [16][2];
    logic [22:0]  m_tag   [16][2];
    logic [255:0] m_line  [16][2];
    logic         m_lru   [16];

    int           exp_stall;
    logic         exp_wb, exp_alloc;
    logic [31:0]  exp_wb_addr, exp_alloc_addr, exp_rdata;
    logic [255:0] exp_wb_data;

    int           obs_stall, obs_ntx;
    logic         obs_wb_seen, obs_timeout;
    logic [31:0]  obs_wb_addr, obs_alloc_addr, obs_rdata;
    logic [255:0] obs_wb_data;

    function automatic logic [255:0] init_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = a ^ (32'(w) * 32'h01010101) ^ 32'h5A5A0000;
        if (a == 32'h0) l[31:0] = 32'h11111111;
        return l;
    endfunction

    function automatic logic [255:0] phys_read(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
    endfunction

    function automatic logic [255:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    task automatic ref_reset();
        for (int s = 0; s < 16; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    // Expected outcome of one CPU access with memory ack delay d, then commit it to the model.
    task automatic ref_access(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                              input int d);
        logic [22:0] tag;
        int idx, wd, way, v;
        tag = addr[31:9];
        idx = int'(addr[8:5]);
        wd  = int'(addr[4:2]);
        way = -1;
        exp_wb = 1'b0;
        exp_alloc = 1'b0;
        exp_stall = 0;
        for (int k = 0; k < 2; k++)
            if (m_valid[idx][k] && m_tag[idx][k] == tag) way = k;
        if (way < 0) begin
            v = !m_valid[idx][0] ? 0 : (!m_valid[idx][1] ? 1 : int'(m_lru[idx]));
            exp_alloc = 1'b1;
            exp_alloc_addr = {addr[31:5], 5'b0};
            if (m_valid[idx][v] && m_dirty[idx][v]) begin
                exp_wb = 1'b1;
                exp_wb_addr = {m_tag[idx][v], addr[8:5], 5'b0};
                exp_wb_data = m_line[idx][v];
                ref_mem[exp_wb_addr] = m_line[idx][v];
                exp_stall = 2 * d + 3;
            end else begin
                exp_stall = d + 2;
            end
            m_line[idx][v]  = ref_read(exp_alloc_addr);
            m_valid[idx][v] = 1'b1;
            m_dirty[idx][v] = 1'b0;
            m_tag[idx][v]   = tag;
            way = v;
        end
        exp_rdata = m_line[idx][way][wd*32 +: 32];
        if (wr) begin
            m_line[idx][way][wd*32 +: 32] = wdata;
            m_dirty[idx][way] = 1'b1;
        end
        m_lru[idx] = (way == 0);
    endtask

    // Present one request until it completes, acting as memory with ack delay d. Starts at posedge+1.
    task automatic access(input logic [31:0] addr, input logic wr, input logic rd,
                          input logic [31:0] wdata, input int d);
        int cnt;
        logic done;
        p1_addr_i = addr; p1_data_i = wdata; p1_MemWrite_i = wr; p1_MemRead_i = rd;
        obs_stall = 0; obs_ntx = 0; obs_wb_seen = 1'b0; obs_timeout = 1'b0;
        obs_wb_addr = '1; obs_alloc_addr = '1; obs_wb_data = '0; obs_rdata = '0;
        cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (!p1_stall_o) begin
                obs_rdata = p1_data_o;
                done = 1'b1;
            end else begin
                obs_stall++;
                if (mem_enable_o) begin
                    if (cnt == 0) begin
                        obs_ntx++;
                        if (mem_write_o) begin
                            obs_wb_seen = 1'b1;
                            obs_wb_addr = mem_addr_o;
                            obs_wb_data = mem_data_o;
                        end else begin
                            obs_alloc_addr = mem_addr_o;
                        end
                    end
                    if (cnt == d) begin
                        mem_ack_i = 1'b1;
                        if (mem_write_o) phys_mem[mem_addr_o] = mem_data_o;
                        else             mem_data_i = phys_read(mem_addr_o);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
            @(posedge clk_i); #1;
        end
        if (!done) obs_timeout = 1'b1;
        mem_ack_i = 1'b0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        #12;
        checks++;
        if (p1_stall_o !== 1'b0 || mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stall=%b en=%b wr=%b required 0 0 0", p1_stall_o, mem_enable_o, mem_write_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_data_o !== 256'h0 || p1_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h data_o=%h p1_data=%h required zeros", mem_addr_o, mem_data_o, p1_data_o);
        end
        ref_reset();
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;
        $display("txn reset released");
    endtask

    task automatic test_clean_miss();
        access(32'h000, 1'b0, 1'b1, 32'h0, 3);
        ref_access(32'h000, 1'b0, 32'h0, 3);
        $display("txn T1 read 0x000 stall=%0d data=%h", obs_stall, obs_rdata);
        checks++;
        if (obs_timeout || obs_stall !== 5) begin
            errors++;
            $display("FAIL t1_stall: got %0d (timeout=%b) required 5", obs_stall, obs_timeout);
        end
        checks++;
        if (obs_alloc_addr !== 32'h0 || obs_wb_seen !== 1'b0) begin
            errors++;
            $display("FAIL t1_alloc: addr=%h wb=%b required 00000000 0", obs_alloc_addr, obs_wb_seen);
        end
        checks++;
        if (obs_rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL t1_data: got %h required 11111111", obs_rdata);
        end
    endtask

    task automatic test_write_hit();
        access(32'h004, 1'b1, 1'b0, 32'hDEADBEEF, 2);
        ref_access(32'h004, 1'b1, 32'hDEADBEEF, 2);
        $display("txn T2 write 0x004 stall=%0d tx=%0d", obs_stall, obs_ntx);
        checks++;
        if (obs_stall !== 0 || obs_ntx !== 0) begin
            errors++;
            $display("FAIL t2_write_hit: stall=%0d tx=%0d required 0 0", obs_stall, obs_ntx);
        end
        access(32'h004, 1'b0, 1'b1, 32'h0, 2);
        ref_access(32'h004, 1'b0, 32'h0, 2);
        $display("txn T2 read 0x004 stall=%0d data=%h", obs_stall, obs_rdata);
        checks++;
        if (obs_stall !== 0 || obs_ntx !== 0 || obs_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL t2_read_hit: stall=%0d tx=%0d data=%h required 0 0 deadbeef", obs_stall, obs_ntx, obs_rdata);
        end
    endtask

    task automatic test_second_way();
        logic [255:0] l;
        l = init_line(32'h200);
        access(32'h200, 1'b0, 1'b1, 32'h0, 1);
        ref_access(32'h200, 1'b0, 32'h0, 1);
        $display("txn T3 read 0x200 stall=%0d alloc=%h wb=%b", obs_stall, obs_alloc_addr, obs_wb_seen);
        checks++;
        if (obs_wb_seen !== 1'b0 || obs_ntx !== 1 || obs_alloc_addr !== 32'h200 || obs_stall !== 3) begin
            errors++;
            $display("FAIL t3_alloc: wb=%b tx=%0d addr=%h stall=%0d required 0 1 00000200 3", obs_wb_seen, obs_ntx, obs_alloc_addr, obs_stall);
        end
        checks++;
        if (obs_rdata !== l[31:0]) begin
            errors++;
            $display("FAIL t3_data: got %h required %h", obs_rdata, l[31:0]);
        end
    endtask

    task automatic test_dirty_evict();
        access(32'h000, 1'b1, 1'b0, 32'h0BADF00D, 2);
        ref_access(32'h000, 1'b1, 32'h0BADF00D, 2);
        checks++;
        if (obs_stall !== 0) begin
            errors++;
            $display("FAIL t4_write0: stall=%0d required 0", obs_stall);
        end
        access(32'h200, 1'b0, 1'b1, 32'h0, 2);
        ref_access(32'h200, 1'b0, 32'h0, 2);
        checks++;
        if (obs_stall !== 0) begin
            errors++;
            $display("FAIL t4_read200: stall=%0d required 0", obs_stall);
        end
        access(32'h400, 1'b0, 1'b1, 32'h0, 2);
        ref_access(32'h400, 1'b0, 32'h0, 2);
        $display("txn T4 read 0x400 stall=%0d wb=%h alloc=%h", obs_stall, obs_wb_addr, obs_alloc_addr);
        checks++;
        if (obs_wb_seen !== 1'b1 || obs_wb_addr !== 32'h0 || obs_wb_data[63:32] !== 32'hDEADBEEF
            || obs_wb_data[31:0] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL t4_wb: seen=%b addr=%h data=%h required 1 00000000 ..deadbeef0badf00d", obs_wb_seen, obs_wb_addr, obs_wb_data[63:0]);
        end
        checks++;
        if (obs_alloc_addr !== 32'h400 || obs_stall !== 7 || obs_ntx !== 2) begin
            errors++;
            $display("FAIL t4_alloc: addr=%h stall=%0d tx=%0d required 00000400 7 2", obs_alloc_addr, obs_stall, obs_ntx);
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        $display("txn stats hit=%0d miss=%0d wb=%0d", hit_cnt_o, miss_cnt_o, wb_cnt_o);
        checks++;
        if (miss_cnt_o !== 32'd3 || wb_cnt_o !== 32'd1 || hit_cnt_o !== 32'd4) begin
            errors++;
            $display("FAIL stats: hit=%0d miss=%0d wb=%0d required 4 3 1", hit_cnt_o, miss_cnt_o, wb_cnt_o);
        end
    endtask
`endif

    task automatic test_async_reset();
        p1_addr_i = 32'h600; p1_MemRead_i = 1'b1; p1_MemWrite_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checks++;
        if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h600) begin
            errors++;
            $display("FAIL t5_alloc_wait: en=%b wr=%b addr=%h required 1 0 00000600", mem_enable_o, mem_write_o, mem_addr_o);
        end
        #2 rst_i = 1'b0;
        #1;
        $display("txn T5 reset mid-alloc en=%b addr=%h", mem_enable_o, mem_addr_o);
        checks++;
        if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL t5_async: en=%b wr=%b addr=%h required 0 0 00000000", mem_enable_o, mem_write_o, mem_addr_o);
        end
        p1_MemRead_i = 1'b0;
        @(negedge clk_i) rst_i = 1'b1;
        ref_reset();
        @(negedge clk_i);
        mem_ack_i = 1'b1;
        mem_data_i = '1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_enable_o !== 1'b0 || p1_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_stale_ack: en=%b stall=%b required 0 0", mem_enable_o, p1_stall_o);
        end
        @(posedge clk_i); #1;
        access(32'h400, 1'b0, 1'b1, 32'h0, 2);
        ref_access(32'h400, 1'b0, 32'h0, 2);
        $display("txn T5 read 0x400 stall=%0d alloc=%h data=%h", obs_stall, obs_alloc_addr, obs_rdata);
        checks++;
        if (obs_stall !== 4 || obs_alloc_addr !== 32'h400 || obs_wb_seen !== 1'b0 || obs_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL t5_remiss: stall=%0d alloc=%h wb=%b data=%h required 4 00000400 0 %h", obs_stall, obs_alloc_addr, obs_wb_seen, obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wdata;
        logic wr, rd;
        int kind, d;
        for (int n = 0; n < 80; n++) begin
            addr  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
                  | (32'($urandom_range(0, 7)) << 2);
            wdata = $urandom;
            kind  = $urandom_range(0, 3);
            d     = $urandom_range(0, 4);
            wr    = (kind >= 2);
            rd    = (kind != 2);
            access(addr, wr, rd, wdata, d);
            ref_access(addr, wr, wdata, d);
            $display("txn rnd %0d addr=%h wr=%b rd=%b d=%0d stall=%0d data=%h", n, addr, wr, rd, d, obs_stall, obs_rdata);
            checks++;
            if (obs_timeout || obs_stall !== exp_stall || obs_wb_seen !== exp_wb) begin
                errors++;
                $display("FAIL rnd_flow %0d: stall=%0d wb=%b timeout=%b required %0d %b 0", n, obs_stall, obs_wb_seen, obs_timeout, exp_stall, exp_wb);
            end
            if (exp_wb) begin
                checks++;
                if (obs_wb_addr !== exp_wb_addr || obs_wb_data !== exp_wb_data) begin
                    errors++;
                    $display("FAIL rnd_wb %0d: addr=%h data=%h required %h %h", n, obs_wb_addr, obs_wb_data, exp_wb_addr, exp_wb_data);
                end
            end
            if (exp_alloc) begin
                checks++;
                if (obs_alloc_addr !== exp_alloc_addr) begin
                    errors++;
                    $display("FAIL rnd_alloc %0d: addr=%h required %h", n, obs_alloc_addr, exp_alloc_addr);
                end
            end
            if (!wr) begin
                checks++;
                if (obs_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL rnd_rdata %0d: got %h required %h", n, obs_rdata, exp_rdata);
                end
            end
        end
    endtask

    initial begin
        p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_second_way();
        test_dirty_evict();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
